// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-hazard stalls, branch/jump flushes, data-memory
// wait handling with timeout, and saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           id_rs,
   input  logic [4:0]           id_rt,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic [4:0]           ex_rd,
   input  logic [4:0]           mem_rd,
   input  logic [4:0]           wb_rd,
   input  logic                 ex_reg_write,
   input  logic                 mem_reg_write,
   input  logic                 wb_reg_write,
   input  logic                 ex_is_jump,
   input  logic                 mem_branch_taken,
   input  logic                 mem_access,
   input  logic                 mem_ack,
   output logic                 mem_req,
   output logic                 pc_write_en,
   output logic                 if_id_write_en,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 ex_mem_flush,
   output logic                 freeze,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [7:0]           WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       req_raw;
   logic       rs_hit, rt_hit, hazard;
   logic       stall_inc, flush_inc;

   function automatic logic src_hit(input logic uses, input logic [4:0] r,
                                    input logic [4:0] e_rd, input logic e_we,
                                    input logic [4:0] m_rd, input logic m_we,
                                    input logic [4:0] w_rd, input logic w_we);
      return uses && (r != 5'd0) &&
             ((e_we && (e_rd == r)) || (m_we && (m_rd == r)) || (w_we && (w_rd == r)));
   endfunction

   assign rs_hit = src_hit(id_uses_rs, id_rs, ex_rd, ex_reg_write,
                           mem_rd, mem_reg_write, wb_rd, wb_reg_write);
   assign rt_hit = src_hit(id_uses_rt, id_rt, ex_rd, ex_reg_write,
                           mem_rd, mem_reg_write, wb_rd, wb_reg_write);
   assign hazard = rs_hit || rt_hit;

   // mem_req/mem_ack: a request is outstanding while mem_req=1; the access
   // completes in the cycle where mem_ack=1 and mem_req=1 (zero-wait if first cycle).
   assign req_raw   = mem_access && (state != ERROR);
   assign error     = (state == ERROR);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (req_raw && !mem_ack) state_nxt = MEM_WAIT;
         MEM_WAIT: if (mem_ack)                    state_nxt = RUN;
                   else if (wait_cnt == WAIT_LAST) state_nxt = ERROR;
         ERROR:    state_nxt = ERROR;
         default:  state_nxt = RUN;
      endcase
   end

   always_comb begin
      mem_req        = 1'b0;
      freeze         = 1'b0;
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      if (!rst) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         if_id_flush    = 1'b1;
         id_ex_flush    = 1'b1;
         ex_mem_flush   = 1'b1;
      end else begin
         mem_req = req_raw;
         freeze  = (req_raw && !mem_ack) || (state == ERROR);
         if (freeze) begin
            // Branch/jump flushes wait here until the freeze lifts.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
         end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
         end else if (ex_is_jump) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
         end else if (hazard) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            stall_inc      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)                                 wait_cnt <= 8'd0;
      else if (state != MEM_WAIT)               wait_cnt <= 8'd0;
      else if (!mem_ack)                        wait_cnt <= wait_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule
